// File: rtl/f3_pkg.sv
// Shared definitions for the function-3 sliding-tile puzzle engine.
package f3_pkg;

    // Decoded key-command codes from the function-3 key processor.
    localparam logic [3:0] F3_NONE    = 4'd0;
    localparam logic [3:0] F3_NORTH   = 4'd1;
    localparam logic [3:0] F3_EAST    = 4'd2;
    localparam logic [3:0] F3_WEST    = 4'd3;
    localparam logic [3:0] F3_SOUTH   = 4'd4;
    localparam logic [3:0] F3_RESTART = 4'd5;

    // Blank-tile direction; the encoding equals the scramble LFSR selection
    // and also (instruction - 1) for the four direction codes.
    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_W = 2'd2,
        DIR_S = 2'd3
    } f3_dir_e;

    // Position p holds p+1, position 15 holds the blank.
    localparam logic [63:0] F3_SOLVED_BOARD = 64'h0FED_CBA9_8765_4321;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        SCRAMBLE = 2'd2
    } f3_state_e;

    typedef struct packed {
        logic       legal;
        logic [3:0] pos;
    } f3_move_t;

    // Neighbour of the blank in the given direction, and whether that
    // neighbour exists on the 4x4 grid (pos[3:2] = row, pos[1:0] = col).
    function automatic f3_move_t f3_neighbour(input logic [3:0] blank, input f3_dir_e dir);
        f3_move_t m;
        m.legal = 1'b0;
        m.pos   = blank;
        case (dir)
            DIR_N: if (blank[3:2] != 2'd0) begin m.legal = 1'b1; m.pos = blank - 4'd4; end
            DIR_S: if (blank[3:2] != 2'd3) begin m.legal = 1'b1; m.pos = blank + 4'd4; end
            DIR_W: if (blank[1:0] != 2'd0) begin m.legal = 1'b1; m.pos = blank - 4'd1; end
            DIR_E: if (blank[1:0] != 2'd3) begin m.legal = 1'b1; m.pos = blank + 4'd1; end
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/f3_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left.
module f3_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    // Next value: shift left, feed back the XOR of the tap bits into bit 0.
    always_comb begin
        value_d = {value_q[14:0], value_q[15] ^ value_q[13] ^ value_q[12] ^ value_q[10]};
    end

    // LFSR register, reloaded with the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/f3_puzzle_engine.sv
// Function-3 game-state engine: applies blank-tile moves, restart and
// LFSR scrambling, and holds the 4x4 board for the renderer.
module f3_puzzle_engine
    import f3_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  instruction,
    input  logic        scramble,
    output logic [63:0] board,
    output logic [3:0]  blank_pos,
    output logic [15:0] move_count,
    output logic        solved,
    output logic        busy
);

    f3_state_e   state_q, state_d;
    logic [3:0]  board_q [16];
    logic [3:0]  board_d [16];
    logic [3:0]  blank_q, blank_d;
    logic [15:0] move_count_q, move_count_d;
    logic        solved_q, solved_d;
    logic        busy_q, busy_d;

    logic [15:0] lfsr_value;
    logic [63:0] board_flat;
    logic [3:0]  instr_eff;
    logic        move_req;
    logic        move_counted;
    logic        do_restart;
    f3_dir_e     move_dir;
    f3_move_t    nb;

    f3_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_value)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_flat
            assign board_flat[4*gi +: 4] = board_q[gi];
        end
    endgenerate

    // Command FSM plus the single shared move/restart datapath.
    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        blank_d      = blank_q;
        move_count_d = move_count_q;
        move_req     = 1'b0;
        move_counted = 1'b0;
        do_restart   = 1'b0;
        move_dir     = DIR_N;
        instr_eff    = (instruction > F3_RESTART) ? F3_NONE : instruction;

        case (state_q)
            IDLE: begin
                if (instr_eff == F3_RESTART) begin
                    do_restart = 1'b1;
                    state_d    = HELD;
                end else if (scramble) begin
                    move_count_d = 16'd0;
                    state_d      = SCRAMBLE;
                end else if (instr_eff != F3_NONE) begin
                    move_req     = 1'b1;
                    move_counted = 1'b1;
                    move_dir     = f3_dir_e'(instr_eff[1:0] - 2'd1);
                    state_d      = HELD;
                end
            end
            HELD: begin
                // One action per press: wait for every command to be released.
                if (instr_eff == F3_NONE && !scramble) begin
                    state_d = IDLE;
                end
            end
            SCRAMBLE: begin
                if (instr_eff == F3_RESTART) begin
                    do_restart = 1'b1;
                    state_d    = HELD;
                end else if (!scramble) begin
                    state_d = (instr_eff == F3_NONE) ? IDLE : HELD;
                end else begin
                    move_req = 1'b1;
                    move_dir = f3_dir_e'(lfsr_value[1:0]);
                end
            end
            default: state_d = IDLE;
        endcase

        nb = f3_neighbour(blank_q, move_dir);

        if (do_restart) begin
            for (int i = 0; i < 16; i++) begin
                board_d[i] = F3_SOLVED_BOARD[4*i +: 4];
            end
            blank_d      = 4'd15;
            move_count_d = 16'd0;
        end else if (move_req && nb.legal) begin
            board_d[blank_q] = board_q[nb.pos];
            board_d[nb.pos]  = 4'd0;
            blank_d          = nb.pos;
            if (move_counted && move_count_q != 16'hFFFF) begin
                move_count_d = move_count_q + 16'd1;
            end
        end

        // Status flags trail the board by one edge; busy tracks the next state.
        solved_d = (board_flat == F3_SOLVED_BOARD);
        busy_d   = (state_d == SCRAMBLE);
    end

    // State, board and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < 16; i++) begin
                board_q[i] <= F3_SOLVED_BOARD[4*i +: 4];
            end
            blank_q      <= 4'd15;
            move_count_q <= 16'd0;
            solved_q     <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            blank_q      <= blank_d;
            move_count_q <= move_count_d;
            solved_q     <= solved_d;
            busy_q       <= busy_d;
        end
    end

    assign board      = board_flat;
    assign blank_pos  = blank_q;
    assign move_count = move_count_q;
    assign solved     = solved_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_f3_puzzle_engine.sv
// Randomized self-checking bench for f3_puzzle_engine against a behavioural
// puzzle model (tile array, row/column arithmetic, integer LFSR).
module tb_f3_puzzle_engine;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [63:0] SOLVED_CONST = 64'h0FED_CBA9_8765_4321;

    logic        clk;
    logic        rst;
    logic [3:0]  instruction;
    logic        scramble;
    logic [63:0] board;
    logic [3:0]  blank_pos;
    logic [15:0] move_count;
    logic        solved;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    // Reference model state.
    int m_board [16];
    int m_blank;
    int m_count;
    int m_mode;      // 0 armed, 1 waiting for release, 2 scrambling
    int m_lfsr;
    bit m_solved;
    bit m_busy;

    f3_puzzle_engine #(.SEED(SEED)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .scramble    (scramble),
        .board       (board),
        .blank_pos   (blank_pos),
        .move_count  (move_count),
        .solved      (solved),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d obs=%h exp=%h", tag, cycle, obs, exp);
        end
    endtask

    function automatic bit m_is_solved();
        for (int p = 0; p < 15; p++) begin
            if (m_board[p] != p + 1) return 1'b0;
        end
        return m_board[15] == 0;
    endfunction

    task automatic m_restart();
        for (int p = 0; p < 15; p++) m_board[p] = p + 1;
        m_board[15] = 0;
        m_blank = 15;
        m_count = 0;
    endtask

    // d: 0 north, 1 east, 2 west, 3 south.
    task automatic m_try(input int d, input bit counted);
        int row, col, tgt;
        row = m_blank / 4;
        col = m_blank % 4;
        tgt = -1;
        case (d)
            0: if (row > 0) tgt = m_blank - 4;
            1: if (col < 3) tgt = m_blank + 1;
            2: if (col > 0) tgt = m_blank - 1;
            3: if (row < 3) tgt = m_blank + 4;
            default: ;
        endcase
        if (tgt >= 0) begin
            m_board[m_blank] = m_board[tgt];
            m_board[tgt] = 0;
            m_blank = tgt;
            if (counted && m_count < 65535) m_count++;
        end
    endtask

    task automatic m_step(input bit r, input int instr_in, input bit scr);
        int i;
        int fb;
        i = (instr_in > 5) ? 0 : instr_in;
        if (r) begin
            m_restart();
            m_mode   = 0;
            m_lfsr   = SEED;
            m_solved = 1'b1;
            m_busy   = 1'b0;
            return;
        end
        m_solved = m_is_solved();
        if (m_mode == 0) begin
            if (i == 5) begin
                m_restart();
                m_mode = 1;
            end else if (scr) begin
                m_count = 0;
                m_mode = 2;
            end else if (i != 0) begin
                m_try(i - 1, 1'b1);
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (i == 0 && !scr) m_mode = 0;
        end else begin
            if (i == 5) begin
                m_restart();
                m_mode = 1;
            end else if (!scr) begin
                m_mode = (i == 0) ? 0 : 1;
            end else begin
                m_try(m_lfsr % 4, 1'b0);
            end
        end
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
        m_busy = (m_mode == 2);
    endtask

    task automatic compare_all();
        logic [63:0] exp_board;
        logic [15:0] seen;
        for (int p = 0; p < 16; p++) exp_board[4*p +: 4] = 4'(m_board[p]);
        check("board", board, exp_board);
        check("blank_pos", 64'(blank_pos), 64'(m_blank));
        check("move_count", 64'(move_count), 64'(m_count));
        check("solved", 64'(solved), 64'(m_solved));
        check("busy", 64'(busy), 64'(m_busy));
        seen = 16'd0;
        for (int p = 0; p < 16; p++) seen[board[4*p +: 4]] = 1'b1;
        check("permutation", 64'(seen), 64'hFFFF);
        check("blank_tile", 64'(board[4*blank_pos +: 4]), 64'd0);
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge.
    task automatic tick(input bit r, input int instr_in, input bit scr);
        rst         = r;
        instruction = 4'(instr_in);
        scramble    = scr;
        @(posedge clk);
        m_step(r, instr_in, scr);
        @(negedge clk);
        cycle++;
        compare_all();
        $display("cyc=%0d rst=%0b instr=%0d scr=%0b blank=%0d count=%0d solved=%0b busy=%0b",
                 cycle, r, instr_in, scr, blank_pos, move_count, solved, busy);
    endtask

    task automatic press(input int instr_in, input int hold);
        for (int k = 0; k < hold; k++) tick(1'b0, instr_in, 1'b0);
        tick(1'b0, 0, 1'b0);
    endtask

    initial begin
        bit scr_r;
        int ins;
        rst = 1'b1;
        instruction = 4'd0;
        scramble = 1'b0;
        @(negedge clk);
        tick(1'b1, 0, 1'b0);
        tick(1'b1, 0, 1'b0);
        check("reset_board", board, SOLVED_CONST);
        check("reset_blank", 64'(blank_pos), 64'd15);
        check("reset_count", 64'(move_count), 64'd0);
        check("reset_solved", 64'(solved), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);

        // South is illegal from row 3.
        press(4, 3);
        check("south_illegal_blank", 64'(blank_pos), 64'd15);
        check("south_illegal_count", 64'(move_count), 64'd0);
        check("south_illegal_solved", 64'(solved), 64'd1);

        // Held North moves exactly once.
        tick(1'b0, 1, 1'b0);
        check("north_blank", 64'(blank_pos), 64'd11);
        check("north_tile15", 64'(board[63:60]), 64'd12);
        check("north_count", 64'(move_count), 64'd1);
        for (int k = 0; k < 4; k++) tick(1'b0, 1, 1'b0);
        check("north_once_blank", 64'(blank_pos), 64'd11);
        check("north_solved", 64'(solved), 64'd0);
        tick(1'b0, 0, 1'b0);
        press(4, 1);
        tick(1'b0, 0, 1'b0);
        check("south_back_blank", 64'(blank_pos), 64'd15);
        check("south_back_solved", 64'(solved), 64'd1);
        check("south_back_count", 64'(move_count), 64'd2);

        // 1 -> 3 without release fires only the North.
        tick(1'b0, 1, 1'b0);
        tick(1'b0, 3, 1'b0);
        tick(1'b0, 3, 1'b0);
        tick(1'b0, 0, 1'b0);
        check("no_refire_blank", 64'(blank_pos), 64'd11);

        // Scramble for 100 cycles, then restart while still scrambling.
        press(5, 1);
        for (int k = 0; k < 100; k++) begin
            tick(1'b0, 0, 1'b1);
            check("scr_busy", 64'(busy), 64'd1);
            check("scr_count", 64'(move_count), 64'd0);
        end
        tick(1'b0, 5, 1'b1);
        check("scr_restart_board", board, SOLVED_CONST);
        check("scr_restart_blank", 64'(blank_pos), 64'd15);
        check("scr_restart_busy", 64'(busy), 64'd0);
        tick(1'b0, 0, 1'b1);
        check("held_no_rescramble", 64'(busy), 64'd0);
        tick(1'b0, 0, 1'b0);

        // Reset during scramble.
        for (int k = 0; k < 20; k++) tick(1'b0, 0, 1'b1);
        tick(1'b1, 2, 1'b1);
        check("rst_scr_board", board, SOLVED_CONST);
        check("rst_scr_blank", 64'(blank_pos), 64'd15);
        check("rst_scr_busy", 64'(busy), 64'd0);
        check("rst_scr_solved", 64'(solved), 64'd1);
        tick(1'b0, 0, 1'b0);

        // Saturation of the move counter.
        force dut.move_count_q = 16'hFFFE;
        #1;
        release dut.move_count_q;
        m_count = 65534;
        press(1, 1);
        press(4, 1);
        press(1, 1);
        check("saturate", 64'(move_count), 64'hFFFF);

        // Random traffic.
        scr_r = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 29) == 0) scr_r = ~scr_r;
            if ($urandom_range(0, 1) == 0) ins = 0;
            else ins = $urandom_range(0, 15);
            if (ins == 5 && $urandom_range(0, 3) != 0) ins = 0;
            tick($urandom_range(0, 299) == 0, ins, scr_r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
